// File: rtl/if_fetch_buf.sv
// if_fetch_buf: instruction-fetch stage placed directly after the PC register.
//
// Issues in-order requests to instruction memory (req/gnt, then in-order rvalid
// responses) and queues each fetched instruction with its address in a small
// FIFO toward decode. A slot is reserved at grant time and filled when its
// response arrives, so decode always sees program order. A taken jump empties
// the FIFO, and the responses still in flight at that moment are counted and
// dropped as they return.
//
// Ports:
//   clk            core clock, all state updates on posedge
//   rst            asynchronous active-low reset
//   pc_i           current fetch PC
//   jump_en_i      jump taken this cycle: flush, no request
//   pc_hold_o      PC must hold next cycle (a jump overrides this in the PC)
//   imem_req_o     fetch request valid
//   imem_addr_o    fetch address (= pc_i)
//   imem_gnt_i     request accepted this cycle
//   imem_rvalid_i  response valid (in request order)
//   imem_rdata_i   response instruction word
//   inst_valid_o   head entry filled and presented
//   inst_o         head instruction, NOP_INST when not valid
//   inst_addr_o    head address, 0 when not valid
//   id_ready_i     decode accepts the head entry
//
// Optional build macro IFU_PERF_CNT_EN adds fetch_cnt_o / drop_cnt_o
// performance counters and simulation assertions on protocol errors.

module if_fetch_buf #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned MAX_OUT  = 2,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_i,
  input  logic        jump_en_i,
  output logic        pc_hold_o,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o,
`ifdef IFU_PERF_CNT_EN
  output logic [31:0] fetch_cnt_o,
  output logic [31:0] drop_cnt_o,
`endif
  input  logic        id_ready_i
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned OutW = $clog2(MAX_OUT + 1);

  localparam logic [CntW-1:0] DepthC  = CntW'(DEPTH);
  localparam logic [OutW-1:0] MaxOutC = OutW'(MAX_OUT);

  logic [31:0]     addr_q   [DEPTH];
  logic [31:0]     inst_q   [DEPTH];
  logic [DEPTH-1:0] filled_q;

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] fill_ptr_q, fill_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [OutW-1:0] out_cnt_q, out_cnt_d;
  logic [OutW-1:0] discard_cnt_q, discard_cnt_d;

  logic grant;
  logic resp_ok;
  logic resp_drop;
  logic resp_fill;
  logic pop;

  // Issue depends only on registered occupancy; a same-cycle pop does not
  // free a slot for issue. Reset gating keeps the request low while held.
  assign imem_req_o  = rst & ~jump_en_i & (count_q < DepthC) & (out_cnt_q < MaxOutC);
  assign imem_addr_o = pc_i;
  assign pc_hold_o   = ~(imem_req_o & imem_gnt_i);

  assign inst_valid_o = (count_q != '0) & filled_q[rd_ptr_q];
  assign inst_o       = inst_valid_o ? inst_q[rd_ptr_q] : NOP_INST;
  assign inst_addr_o  = inst_valid_o ? addr_q[rd_ptr_q] : 32'h0;

  always_comb begin
    grant     = imem_req_o & imem_gnt_i;
    // A response with nothing outstanding is a protocol error and is ignored.
    resp_ok   = imem_rvalid_i & (out_cnt_q != '0);
    resp_drop = resp_ok & (discard_cnt_q != '0);
    resp_fill = resp_ok & (discard_cnt_q == '0);
    pop       = inst_valid_o & id_ready_i & ~jump_en_i;

    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    fill_ptr_d    = fill_ptr_q;
    count_d       = count_q;
    out_cnt_d     = out_cnt_q + OutW'(grant) - OutW'(resp_ok);
    discard_cnt_d = discard_cnt_q - OutW'(resp_drop);

    if (jump_en_i) begin
      wr_ptr_d      = '0;
      rd_ptr_d      = '0;
      fill_ptr_d    = '0;
      count_d       = '0;
      // Everything still in flight after this cycle belongs to the wrong path.
      discard_cnt_d = out_cnt_q - OutW'(resp_ok);
    end else begin
      if (grant) begin
        wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (resp_fill) begin
        fill_ptr_d = fill_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      count_d = count_q + CntW'(grant) - CntW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      fill_ptr_q    <= '0;
      count_q       <= '0;
      out_cnt_q     <= '0;
      discard_cnt_q <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      fill_ptr_q    <= fill_ptr_d;
      count_q       <= count_d;
      out_cnt_q     <= out_cnt_d;
      discard_cnt_q <= discard_cnt_d;
    end
  end

  // Entry storage. The slot being reserved (wr_ptr) is never the slot being
  // filled (fill_ptr): fill targets an already-reserved slot.
  for (genvar g = 0; g < DEPTH; g++) begin : g_entry
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        addr_q[g]   <= 32'h0;
        inst_q[g]   <= 32'h0;
        filled_q[g] <= 1'b0;
      end else if (jump_en_i) begin
        filled_q[g] <= 1'b0;
      end else begin
        if (grant && (wr_ptr_q == PtrW'(g))) begin
          addr_q[g]   <= pc_i;
          filled_q[g] <= 1'b0;
        end
        if (resp_fill && (fill_ptr_q == PtrW'(g))) begin
          inst_q[g]   <= imem_rdata_i;
          filled_q[g] <= 1'b1;
        end
      end
    end
  end

`ifdef IFU_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] drop_cnt_q, drop_cnt_d;
  logic [31:0] flushed_filled;

  always_comb begin
    flushed_filled = 32'h0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if ((CntW'(i) < count_q) && filled_q[rd_ptr_q + PtrW'(i)]) begin
        flushed_filled = flushed_filled + 32'h1;
      end
    end
    fetch_cnt_d = fetch_cnt_q + 32'(grant);
    drop_cnt_d  = drop_cnt_q + 32'(resp_drop);
    if (jump_en_i) begin
      // Live filled entries plus a fill landing in a slot that is being flushed.
      drop_cnt_d = drop_cnt_d + flushed_filled + 32'(resp_fill);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_cnt_q <= 32'h0;
      drop_cnt_q  <= 32'h0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign fetch_cnt_o = fetch_cnt_q;
  assign drop_cnt_o  = drop_cnt_q;

  a_no_spurious_resp : assert property (@(posedge clk) disable iff (!rst)
    !(imem_rvalid_i && (out_cnt_q == '0)));
  a_count_bound : assert property (@(posedge clk) disable iff (!rst)
    count_q <= DepthC);
`endif

endmodule

// File: tb/tb_if_fetch_buf.sv
// Directed bench for if_fetch_buf: a behavioural instruction memory with a
// programmable response latency and a PC register model run in the background;
// each task drives one scenario and checks against hand-derived expectations.
// Memory data for address A is A + 0x1000_0000.

module tb_if_fetch_buf;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] DOFS = 32'h1000_0000;

  logic        clk;
  logic        rst;
  logic [31:0] pc_i;
  logic        jump_en_i;
  logic        pc_hold_o;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic        id_ready_i;

  if_fetch_buf dut (
    .clk          (clk),
    .rst          (rst),
    .pc_i         (pc_i),
    .jump_en_i    (jump_en_i),
    .pc_hold_o    (pc_hold_o),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_gnt_i   (imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i),
    .imem_rdata_i (imem_rdata_i),
    .inst_valid_o (inst_valid_o),
    .inst_o       (inst_o),
    .inst_addr_o  (inst_addr_o),
    .id_ready_i   (id_ready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_err;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t       mq[$];
  logic [31:0] pop_addr[$];
  logic [31:0] pop_inst[$];
  int          cyc;
  int          mem_lat;
  int          n_grant;
  int          n_resp;
  int          max_out;
  int          bad_seen;
  logic [31:0] pc_base;
  logic [31:0] jump_tgt;
  logic [31:0] next_pc;

  // Memory + PC register model: drive at posedge+1, sample at negedge.
  initial begin
    cyc = 0;
    next_pc = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (!rst) begin
        imem_rvalid_i = 1'b0;
        pc_i = pc_base;
      end else begin
        pc_i = next_pc;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
          imem_rvalid_i = 1'b1;
          imem_rdata_i  = mq[0].addr + DOFS;
          void'(mq.pop_front());
          n_resp++;
        end else begin
          imem_rvalid_i = 1'b0;
        end
      end
      @(negedge clk);
      if (!rst) begin
        mq.delete();
        next_pc = pc_base;
      end else begin
        if (imem_req_o && imem_gnt_i) begin
          mq.push_back('{addr: imem_addr_o, due: cyc + mem_lat});
          n_grant++;
        end
        if (n_grant - n_resp > max_out) max_out = n_grant - n_resp;
        next_pc = jump_en_i ? jump_tgt : (pc_hold_o ? pc_i : pc_i + 32'd4);
        if (inst_valid_o && id_ready_i && !jump_en_i) begin
          pop_addr.push_back(inst_addr_o);
          pop_inst.push_back(inst_o);
        end
        if (inst_valid_o && (inst_addr_o == 32'h10 || inst_addr_o == 32'h14)) bad_seen++;
      end
    end
  end

  // Hold the block in reset for a cycle with clean bench state.
  task automatic do_reset(input logic [31:0] base, input int lat);
    @(posedge clk);
    #2;
    rst        = 1'b0;
    imem_gnt_i = 1'b0;
    id_ready_i = 1'b0;
    jump_en_i  = 1'b0;
    pc_base    = base;
    mem_lat    = lat;
    n_grant    = 0;
    n_resp     = 0;
    max_out    = 0;
    bad_seen   = 0;
    pop_addr.delete();
    pop_inst.delete();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    do_reset(32'h0, 1);
    @(negedge clk);
    n_checks++;
    if (imem_req_o !== 1'b0) begin
      n_err++; $display("FAIL reset_req got=%b exp=0", imem_req_o);
    end
    n_checks++;
    if (inst_valid_o !== 1'b0) begin
      n_err++; $display("FAIL reset_valid got=%b exp=0", inst_valid_o);
    end
    n_checks++;
    if (inst_o !== NOP) begin
      n_err++; $display("FAIL reset_inst got=%h exp=%h", inst_o, NOP);
    end
    n_checks++;
    if (inst_addr_o !== 32'h0) begin
      n_err++; $display("FAIL reset_addr got=%h exp=0", inst_addr_o);
    end
    n_checks++;
    if (pc_hold_o !== 1'b1) begin
      n_err++; $display("FAIL reset_hold got=%b exp=1", pc_hold_o);
    end
  endtask

  task automatic test_stream();
    int first;
    int hold_bad;
    first = -1;
    hold_bad = 0;
    do_reset(32'h0, 1);
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #2;
      if (i == 0) begin
        rst = 1'b1;
        imem_gnt_i = 1'b1;
        id_ready_i = 1'b1;
      end
      @(negedge clk);
      if (inst_valid_o && first < 0) first = i;
      if (pc_hold_o) hold_bad++;
    end
    n_checks++;
    if (first !== 2) begin
      n_err++; $display("FAIL stream_latency got=%0d exp=2", first);
    end
    n_checks++;
    if (hold_bad !== 0) begin
      n_err++; $display("FAIL stream_hold got=%0d held cycles exp=0", hold_bad);
    end
    n_checks++;
    if (pop_addr.size() < 8) begin
      n_err++; $display("FAIL stream_pops got=%0d exp>=8", pop_addr.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        n_checks++;
        if (pop_addr[k] !== 32'(4 * k) || pop_inst[k] !== 32'(4 * k) + DOFS) begin
          n_err++;
          $display("FAIL stream_order[%0d] got=%h/%h exp=%h/%h", k, pop_addr[k], pop_inst[k],
                   32'(4 * k), 32'(4 * k) + DOFS);
        end
      end
    end
  endtask

  task automatic test_full_stall();
    do_reset(32'h0, 1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #2;
      if (i == 0) begin
        rst = 1'b1;
        imem_gnt_i = 1'b1;
      end
      @(negedge clk);
    end
    n_checks++;
    if (n_grant !== 4) begin
      n_err++; $display("FAIL stall_grants got=%0d exp=4", n_grant);
    end
    n_checks++;
    if (imem_req_o !== 1'b0 || pc_hold_o !== 1'b1) begin
      n_err++; $display("FAIL stall_req got=%b/%b exp=0/1", imem_req_o, pc_hold_o);
    end
    n_checks++;
    if (inst_valid_o !== 1'b1 || inst_addr_o !== 32'h0 || inst_o !== DOFS) begin
      n_err++;
      $display("FAIL stall_head got=%b/%h/%h exp=1/0/%h", inst_valid_o, inst_addr_o, inst_o, DOFS);
    end
    @(posedge clk);
    #2;
    id_ready_i = 1'b1;
    @(negedge clk);
    n_checks++;
    if (imem_req_o !== 1'b0 || inst_addr_o !== 32'h0) begin
      n_err++; $display("FAIL stall_pop_cycle got=%b/%h exp=0/0", imem_req_o, inst_addr_o);
    end
    @(posedge clk);
    #2;
    id_ready_i = 1'b0;
    @(negedge clk);
    n_checks++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h10 || inst_addr_o !== 32'h4) begin
      n_err++;
      $display("FAIL stall_refill got=%b/%h/%h exp=1/10/4", imem_req_o, imem_addr_o, inst_addr_o);
    end
    @(posedge clk);
    #2;
    @(negedge clk);
    n_checks++;
    if (imem_req_o !== 1'b0 || n_grant !== 5) begin
      n_err++; $display("FAIL stall_refull got=%b/%0d exp=0/5", imem_req_o, n_grant);
    end
  endtask

  task automatic test_max_out();
    logic [7:0] reqv;
    reqv = '0;
    do_reset(32'h0, 5);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #2;
      if (i == 0) begin
        rst = 1'b1;
        imem_gnt_i = 1'b1;
        id_ready_i = 1'b1;
      end
      @(negedge clk);
      reqv[i] = imem_req_o;
    end
    n_checks++;
    if (reqv !== 8'b1100_0011) begin
      n_err++; $display("FAIL maxout_req_pattern got=%b exp=11000011", reqv);
    end
    n_checks++;
    if (max_out !== 2) begin
      n_err++; $display("FAIL maxout_outstanding got=%0d exp=2", max_out);
    end
  endtask

  task automatic test_flush();
    int first;
    logic req_at_jump;
    first = -1;
    req_at_jump = 1'b1;
    jump_tgt = 32'h100;
    do_reset(32'h10, 3);
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #2;
      if (i == 0) begin
        rst = 1'b1;
        imem_gnt_i = 1'b1;
        id_ready_i = 1'b1;
      end
      jump_en_i = (i == 2);
      @(negedge clk);
      if (i == 2) req_at_jump = imem_req_o;
      if (inst_valid_o && first < 0) first = i;
    end
    jump_en_i = 1'b0;
    n_checks++;
    if (req_at_jump !== 1'b0) begin
      n_err++; $display("FAIL flush_no_req got=%b exp=0", req_at_jump);
    end
    n_checks++;
    if (bad_seen !== 0) begin
      n_err++; $display("FAIL flush_wrong_path got=%0d presented exp=0", bad_seen);
    end
    n_checks++;
    if (first !== 8) begin
      n_err++; $display("FAIL flush_first_valid got=%0d exp=8", first);
    end
    n_checks++;
    if (pop_addr.size() < 2) begin
      n_err++; $display("FAIL flush_pops got=%0d exp>=2", pop_addr.size());
    end else begin
      n_checks++;
      if (pop_addr[0] !== 32'h100 || pop_inst[0] !== 32'h100 + DOFS ||
          pop_addr[1] !== 32'h104) begin
        n_err++;
        $display("FAIL flush_target got=%h/%h/%h exp=100/%h/104", pop_addr[0], pop_inst[0],
                 pop_addr[1], 32'h100 + DOFS);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic req_full_pop;
    req_full_pop = 1'b1;
    do_reset(32'h0, 1);
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #2;
      if (i == 0) begin
        rst = 1'b1;
        imem_gnt_i = 1'b1;
      end
      if (i == 6) id_ready_i = 1'b1;
      @(negedge clk);
      if (i == 6) req_full_pop = imem_req_o;
    end
    n_checks++;
    if (req_full_pop !== 1'b0) begin
      n_err++; $display("FAIL b2b_full_pop_req got=%b exp=0", req_full_pop);
    end
    n_checks++;
    if (pop_addr.size() !== 9) begin
      n_err++; $display("FAIL b2b_pop_count got=%0d exp=9", pop_addr.size());
    end
    for (int k = 0; k < pop_addr.size(); k++) begin
      n_checks++;
      if (pop_addr[k] !== 32'(4 * k) || pop_inst[k] !== 32'(4 * k) + DOFS) begin
        n_err++;
        $display("FAIL b2b_order[%0d] got=%h/%h exp=%h/%h", k, pop_addr[k], pop_inst[k],
                 32'(4 * k), 32'(4 * k) + DOFS);
      end
    end
    // Asynchronous reset mid-stream: outputs must drop before the next edge.
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if (inst_valid_o !== 1'b0 || inst_o !== NOP || inst_addr_o !== 32'h0 ||
        imem_req_o !== 1'b0 || pc_hold_o !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_async_reset got=%b/%h/%h/%b/%b exp=0/%h/0/0/1", inst_valid_o, inst_o,
               inst_addr_o, imem_req_o, pc_hold_o, NOP);
    end
  endtask

  initial begin
    n_checks      = 0;
    n_err         = 0;
    rst           = 1'b0;
    pc_i          = 32'h0;
    pc_base       = 32'h0;
    jump_tgt      = 32'h0;
    jump_en_i     = 1'b0;
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = 32'h0;
    id_ready_i    = 1'b0;
    mem_lat       = 1;
    n_grant       = 0;
    n_resp        = 0;
    max_out       = 0;
    bad_seen      = 0;
    test_reset();
    test_stream();
    test_full_stall();
    test_max_out();
    test_flush();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
